// File: rtl/wb_copy_master_if.sv
// ---------------------------------------------------------------------------
// wb_copy_master_if: Wishbone signal bundle between the copy master and the bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wb_copy_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/wb_copy_master.sv
// ---------------------------------------------------------------------------
// wb_copy_master: Wishbone block copier, one single read then one single write per word
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_copy_master #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_adr_i,
  input  logic [31:0]      dst_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] count_o,
  wb_copy_master_if.master wb
);

  // Phase counter only needs to reach TIMEOUT-1 before the abort fires.
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [29:0]      src_ptr;
  logic [29:0]      dst_ptr;
  logic [29:0]      src_next;
  logic [29:0]      dst_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             unused_adr_bits;

  assign src_next        = src_ptr + 30'd1;
  assign dst_next        = dst_ptr + 30'd1;
  assign count_next      = count_o + LEN_W'(1);
  assign tmo_hit         = (tmo_cnt == TMO_LAST);
  assign unused_adr_bits = ^{src_adr_i[1:0], dst_adr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      count_o     <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      len_q       <= '0;
      tmo_cnt     <= '0;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            src_ptr <= src_adr_i[31:2];
            dst_ptr <= dst_adr_i[31:2];
            len_q   <= len_i;
            count_o <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            tmo_cnt <= '0;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state       <= READ;
              wb.wb_cyc_o <= 1'b1;
              wb.wb_stb_o <= 1'b1;
              wb.wb_we_o  <= 1'b0;
              wb.wb_adr_o <= {src_adr_i[31:2], 2'b00};
              wb.wb_sel_o <= 4'hF;
            end
          end
        end

        READ: begin
          if (wb.wb_ack_i) begin
            state       <= WRITE;
            wb.wb_dat_o <= wb.wb_dat_i;
            wb.wb_we_o  <= 1'b1;
            wb.wb_adr_o <= {dst_ptr, 2'b00};
            tmo_cnt     <= '0;
          end else if (tmo_hit) begin
            state       <= DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b1;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_sel_o <= 4'h0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        WRITE: begin
          if (wb.wb_ack_i) begin
            count_o <= count_next;
            src_ptr <= src_next;
            dst_ptr <= dst_next;
            tmo_cnt <= '0;
            // Comparing the incremented count keeps a full-range length from wrapping.
            if (count_next == len_q) begin
              state       <= DONE;
              done_o      <= 1'b1;
              wb.wb_cyc_o <= 1'b0;
              wb.wb_stb_o <= 1'b0;
              wb.wb_we_o  <= 1'b0;
              wb.wb_sel_o <= 4'h0;
            end else begin
              state       <= READ;
              wb.wb_we_o  <= 1'b0;
              wb.wb_adr_o <= {src_next, 2'b00};
            end
          end else if (tmo_hit) begin
            state       <= DONE;
            done_o      <= 1'b1;
            err_o       <= 1'b1;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_sel_o <= 4'h0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
